// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
// Serial receive framer driven by an external bit-period divider. The framer
// holds the divider clear while idle, lets it count during a frame, and
// samples the synchronised RX line on each mid-bit mark pulse to assemble
// start, data (LSB first), optional parity and stop bits.
//
// Parameter ranges: DataBits 5..9, ParityMode 0 (none) / 1 (even) / 2 (odd),
// SyncStages >= 2.

module uart_rx_sampler #(
   parameter int unsigned DataBits   = 8,
   parameter int unsigned ParityMode = 0,
   parameter int unsigned SyncStages = 2
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                rx_i,
   input  logic                div_mark_i,
   output logic                div_clear_o,
   output logic                div_enable_o,
   output logic [DataBits-1:0] data_o,
   output logic                valid_o,
   output logic                frame_err_o,
   output logic                parity_err_o,
   output logic                busy_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t state_q, state_d;

   // Input synchroniser; the line idles high so the chain resets to ones.
   logic [SyncStages-1:0] sync_q, sync_d;
   logic                  rx_s;

   // Frame assembly datapath.
   logic [DataBits-1:0] shift_q, shift_d;
   logic [3:0]          bit_idx_q, bit_idx_d;
   logic                par_err_q, par_err_d;
   logic [DataBits-1:0] data_q, data_d;
   logic                valid_q, valid_d;
   logic                frame_err_q, frame_err_d;
   logic                parity_err_q, parity_err_d;

   logic last_bit;
   logic odd_sel;
   logic exp_par;

   assign rx_s     = sync_q[SyncStages-1];
   assign last_bit = (bit_idx_q == 4'(DataBits - 1));
   assign odd_sel  = (ParityMode == 2);
   assign exp_par  = (^shift_q) ^ odd_sel;

   // Shift the raw line into the synchroniser chain.
   always_comb begin
      sync_d = {sync_q[SyncStages-2:0], rx_i};
   end

   // Synchroniser register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; marks are only honoured while the divider runs.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (div_mark_i) begin
               state_d = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (div_mark_i && last_bit) begin
               state_d = (ParityMode != 0) ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (div_mark_i) begin
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (div_mark_i) begin
               state_d = rx_s ? S_IDLE : S_BREAK;
            end
         end
         S_BREAK: begin
            if (rx_s) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM outputs: divider control and busy flag decoded from state.
   always_comb begin
      div_clear_o  = 1'b1;
      div_enable_o = 1'b0;
      busy_o       = 1'b0;
      unique case (state_q)
         S_START, S_DATA, S_PARITY, S_STOP: begin
            div_clear_o  = 1'b0;
            div_enable_o = 1'b1;
            busy_o       = 1'b1;
         end
         default: begin
            div_clear_o  = 1'b1;
            div_enable_o = 1'b0;
            busy_o       = 1'b0;
         end
      endcase
   end

   // Datapath next values: bit capture, parity check and status pulses.
   always_comb begin
      shift_d      = shift_q;
      bit_idx_d    = bit_idx_q;
      par_err_d    = par_err_q;
      data_d       = data_q;
      valid_d      = 1'b0;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      unique case (state_q)
         S_START: begin
            if (div_mark_i && !rx_s) begin
               shift_d   = '0;
               bit_idx_d = '0;
               par_err_d = 1'b0;
            end
         end
         S_DATA: begin
            if (div_mark_i) begin
               for (int unsigned i = 0; i < DataBits; i++) begin
                  if (bit_idx_q == 4'(i)) begin
                     shift_d[i] = rx_s;
                  end
               end
               bit_idx_d = bit_idx_q + 4'd1;
            end
         end
         S_PARITY: begin
            if (div_mark_i) begin
               par_err_d = (rx_s != exp_par);
            end
         end
         S_STOP: begin
            if (div_mark_i) begin
               data_d = shift_q;
               if (rx_s) begin
                  if (par_err_q) begin
                     parity_err_d = 1'b1;
                  end else begin
                     valid_d = 1'b1;
                  end
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath registers; reset discards any partial word.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         shift_q      <= '0;
         bit_idx_q    <= '0;
         par_err_q    <= 1'b0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         shift_q      <= shift_d;
         bit_idx_q    <= bit_idx_d;
         par_err_q    <= par_err_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign data_o       = data_q;
   assign valid_o      = valid_q;
   assign frame_err_o  = frame_err_q;
   assign parity_err_o = parity_err_q;

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
Serial receive framer that sits directly downstream of the UART bit-period divider. It controls the divider's clear and enable inputs and consumes its mid-bit mark pulse. On each mark it samples a synchronised RX line and assembles start, data, optional parity and stop bits into a parallel byte with status pulses. Intended divider configuration: DivMaxVal = clocks per bit, DivMarkPos = DivMaxVal/2, so each mark falls near bit centre.

Parameters:
DataBits, 8, number of data bits per frame (5..9), received LSB first
ParityMode, 0, 0 = none, 1 = even, 2 = odd
SyncStages, 2, RX input synchroniser depth (>= 2)

Ports:
clk_i  input  1  system clock
reset_i  input  1  synchronous active-high reset
rx_i  input  1  asynchronous serial line, idle high
div_mark_i  input  1  one-cycle mid-bit pulse from the divider
div_clear_o  output  1  holds the divider counter at zero
div_enable_o  output  1  lets the divider count
data_o  output  DataBits  last received data word
valid_o  output  1  one-cycle pulse: good frame in data_o
frame_err_o  output  1  one-cycle pulse: stop bit sampled low
parity_err_o  output  1  one-cycle pulse: parity mismatch (ParityMode != 0)
busy_o  output  1  high while a frame is being received

Behaviour:
- One clock; reset_i is synchronous and active-high.
- Reset values: data_o = 0, valid_o = 0, frame_err_o = 0, parity_err_o = 0, busy_o = 0, div_clear_o = 1, div_enable_o = 0. All synchroniser flops = 1. FSM = IDLE.
- rx_i passes through a SyncStages-deep flop chain; rx_s denotes the final stage. All decisions use rx_s only.
- States and transitions:
  - IDLE: div_clear_o = 1, div_enable_o = 0. When rx_s = 0, go to START.
  - START: clear = 0, enable = 1. On div_mark_i:
    - rx_s = 0: go to DATA with bit index = 0.
    - rx_s = 1: false start; go to IDLE with no status pulse.
  - DATA: on each mark, shift rx_s into bit[index] and increment the index. After DataBits marks, go to PARITY if ParityMode != 0, otherwise go to STOP.
  - PARITY: on mark, compare rx_s with the expected bit. Expected bit is XOR of the data bits for even parity, inverted for odd parity. Latch the mismatch flag; go to STOP.
  - STOP: on mark, load data_o with the assembled word.
    - rx_s = 1: pulse valid_o if there is no parity mismatch, otherwise pulse parity_err_o. Go to IDLE.
    - rx_s = 0: pulse frame_err_o, suppress valid_o and parity_err_o, go to BREAK.
  - BREAK: clear = 1, enable = 0. Wait for rx_s = 1, then go to IDLE. Holding the line low produces exactly one frame_err_o.
- Status pulses:
  - Registered; they assert in the cycle after the stop-bit mark and last exactly one cycle.
  - At most one of valid_o, frame_err_o, parity_err_o is high in any cycle.
- data_o holds its value until the next stop-bit mark. It is updated even on error frames.
- busy_o = 1 in START, DATA, PARITY and STOP; 0 in IDLE and BREAK.
- div_mark_i is ignored in IDLE and BREAK.
- A mark arriving in the same cycle as the IDLE->START transition is ignored, because the divider was held clear.
- reset_i asserted mid-frame:
  - Next cycle: FSM in IDLE, all outputs at reset values, partial word discarded, no status pulse.
  - reset_i has priority over every other event.
- Glitch rejection: a low pulse shorter than half a bit period returns to IDLE via the false-start path.

Test Plan:
1. Bench uses a divider with DivMaxVal = 16, DivMarkPos = 8, DataBits = 8, ParityMode = 0. Send 0xA5 with a stop bit -> data_o = 0xA5 and one valid_o pulse about 10 bit-times after the falling edge; busy_o then falls.
2. Send 0x3C then immediately 0xFF, back-to-back with one stop bit -> two valid_o pulses with data_o = 0x3C, then 0xFF; no error pulses.
3. Drive rx_i low for 4 clocks, then high -> return to IDLE, no status pulse, busy_o falls after the first mark, div_clear_o = 1 again.
4. Send 0x55 with the stop bit low, then hold the line low for 3 bit-times -> a single frame_err_o pulse, data_o = 0x55, no valid_o. Next frame 0x12 is received correctly after the line returns high.
5. ParityMode = 1, send 0x07 with parity bit 0 (expected 1) -> parity_err_o pulse, no valid_o. Resend with parity bit 1 -> valid_o, data_o = 0x07.
6. Assert reset_i during data bit 4 of a frame -> next cycle all outputs are at reset values and no status pulse occurs. A subsequent frame 0x81 yields valid_o with data_o = 0x81.
